// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating direction counters.
// Combinational lookup on the fetch PC, trained at the clock edge by EX
// resolutions, plus saturating resolve/mispredict statistics.
module branch_predictor #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int TAG_BITS  = 8,
  parameter int CTR_BITS  = 2,
  parameter int PRED_MODE = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispredict,
  input  logic            flush_all,
  output logic [31:0]     stat_resolved,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDX = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam bit MODE_BTB = (PRED_MODE != 0);

  // table storage
  logic [ENTRIES-1:0]                r_valid;
  logic [ENTRIES-1:0][TAG_BITS-1:0]  r_tag;
  logic [ENTRIES-1:0][XLEN-1:0]      r_target;
  logic [ENTRIES-1:0]                r_is_jump;
  logic [ENTRIES-1:0][CTR_BITS-1:0]  r_ctr;
  logic [31:0]                       r_stat_res;
  logic [31:0]                       r_stat_mis;

  // lookup side
  logic [IDX-1:0]      w_lk_idx;
  logic [TAG_BITS-1:0] w_lk_tag;
  logic                w_lk_hit;
  logic                w_lk_taken;

  // update side
  logic [IDX-1:0]      w_up_idx;
  logic [TAG_BITS-1:0] w_up_tag;
  logic                w_up_hit;
  logic [CTR_BITS-1:0] w_ctr_cur;
  logic [CTR_BITS-1:0] w_ctr_nxt;

  // PC bits outside index/tag fields never reach the table
  logic [XLEN-1:0]     w_unused_upd_pc;
  assign w_unused_upd_pc = upd_pc;

  assign w_lk_idx = if_pc[IDX+1:2];
  assign w_lk_tag = if_pc[IDX+TAG_BITS+1:IDX+2];
  assign w_up_idx = upd_pc[IDX+1:2];
  assign w_up_tag = upd_pc[IDX+TAG_BITS+1:IDX+2];

  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  // static mode still trains the table but never predicts taken
  assign w_lk_taken  = MODE_BTB && w_lk_hit &&
                       (r_is_jump[w_lk_idx] || r_ctr[w_lk_idx][CTR_BITS-1]);
  assign pred_taken  = w_lk_taken;
  assign pred_target = w_lk_taken ? r_target[w_lk_idx] : (if_pc + XLEN'(4));

  assign stat_resolved    = r_stat_res;
  assign stat_mispredicts = r_stat_mis;

  // saturating next value of the direction counter for a hitting branch
  always_comb begin
    w_ctr_cur = r_ctr[w_up_idx];
    w_ctr_nxt = w_ctr_cur;
    if (upd_taken && (w_ctr_cur != CTR_MAX))
      w_ctr_nxt = w_ctr_cur + CTR_BITS'(1);
    else if (!upd_taken && (w_ctr_cur != '0))
      w_ctr_nxt = w_ctr_cur - CTR_BITS'(1);
  end

  // table training; flush overrides a same-cycle update
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_valid <= '0;
      r_ctr   <= '0;
    end else if (flush_all) begin
      r_valid <= '0;
    end else if (upd_valid) begin
      if (w_up_hit) begin
        r_is_jump[w_up_idx] <= upd_is_jump;
        if (upd_is_jump) begin
          r_target[w_up_idx] <= upd_target;
        end else begin
          r_ctr[w_up_idx] <= w_ctr_nxt;
          if (upd_taken) r_target[w_up_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        r_valid[w_up_idx]   <= 1'b1;
        r_tag[w_up_idx]     <= w_up_tag;
        r_target[w_up_idx]  <= upd_target;
        r_is_jump[w_up_idx] <= upd_is_jump;
        r_ctr[w_up_idx]     <= CTR_WEAK;
      end
    end
  end

  // saturating statistics, counted in both modes and across flushes
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stat_res <= '0;
      r_stat_mis <= '0;
    end else if (upd_valid) begin
      if (r_stat_res != 32'hFFFF_FFFF) r_stat_res <= r_stat_res + 32'd1;
      if (upd_mispredict && (r_stat_mis != 32'hFFFF_FFFF))
        r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: one BTB instance and one static
// instance share all inputs; expected values are hand-computed.
module tb_branch_predictor;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        upd_valid, upd_is_jump, upd_taken, upd_mispredict, flush_all;
  logic [31:0] upd_pc, upd_target;

  logic        p1_taken, p0_taken;
  logic [31:0] p1_target, p0_target;
  logic [31:0] s1_res, s1_mis, s0_res, s0_mis;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  branch_predictor #(.PRED_MODE(1)) dut (
    .clock(clock), .reset(reset), .if_pc(if_pc),
    .pred_taken(p1_taken), .pred_target(p1_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .flush_all(flush_all),
    .stat_resolved(s1_res), .stat_mispredicts(s1_mis)
  );

  branch_predictor #(.PRED_MODE(0)) dut0 (
    .clock(clock), .reset(reset), .if_pc(if_pc),
    .pred_taken(p0_taken), .pred_target(p0_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .flush_all(flush_all),
    .stat_resolved(s0_res), .stat_mispredicts(s0_mis)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one update pulse across a single edge
  task automatic upd(input logic [31:0] pc, input logic jmp, input logic tkn,
                     input logic [31:0] tgt, input logic mis);
    upd_pc = pc; upd_is_jump = jmp; upd_taken = tkn;
    upd_target = tgt; upd_mispredict = mis; upd_valid = 1'b1;
    @(posedge clock); #1;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc; #1;
  endtask

  initial begin
    reset = 1'b0; if_pc = 32'h40;
    upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0; upd_taken = 1'b0;
    upd_target = '0; upd_mispredict = 1'b0; flush_all = 1'b0;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_taken",  {31'b0, p1_taken}, 32'h0);
    chk("rst_target", p1_target, 32'h44);
    chk("rst_res",    s1_res, 32'h0);
    chk("rst_mis",    s1_mis, 32'h0);
    reset = 1'b1;

    // allocate: branch taken, weakly-taken counter
    upd(32'h10, 1'b0, 1'b1, 32'h18, 1'b1);
    look(32'h10);
    chk("alloc_taken",  {31'b0, p1_taken}, 32'h1);
    chk("alloc_target", p1_target, 32'h18);
    chk("alloc_mis",    s1_mis, 32'h1);
    chk("alloc_res",    s1_res, 32'h1);
    chk("m0_taken",     {31'b0, p0_taken}, 32'h0);
    chk("m0_target",    p0_target, 32'h14);
    chk("m0_res",       s0_res, 32'h1);
    chk("m0_mis",       s0_mis, 32'h1);

    // not-taken: ctr 2 -> 1
    upd(32'h10, 1'b0, 1'b0, 32'h18, 1'b0);
    look(32'h10);
    chk("nt_taken",  {31'b0, p1_taken}, 32'h0);
    chk("nt_target", p1_target, 32'h14);

    // saturation: 1 -> 3 (held), then 3 -> 2 still taken
    repeat (4) upd(32'h10, 1'b0, 1'b1, 32'h18, 1'b0);
    upd(32'h10, 1'b0, 1'b0, 32'h18, 1'b0);
    look(32'h10);
    chk("sat_taken",  {31'b0, p1_taken}, 32'h1);
    chk("sat_target", p1_target, 32'h18);
    // 2 -> 1 -> 0
    repeat (2) upd(32'h10, 1'b0, 1'b0, 32'h18, 1'b0);
    look(32'h10);
    chk("sat_nt", {31'b0, p1_taken}, 32'h0);
    chk("sat_res", s1_res, 32'd9);

    // alias: jump at 0x50 evicts 0x10 (same index, new tag)
    upd(32'h10, 1'b0, 1'b1, 32'h18, 1'b0);
    upd(32'h50, 1'b1, 1'b1, 32'h40, 1'b0);
    look(32'h50);
    chk("jmp_taken",  {31'b0, p1_taken}, 32'h1);
    chk("jmp_target", p1_target, 32'h40);
    look(32'h10);
    chk("alias_taken",  {31'b0, p1_taken}, 32'h0);
    chk("alias_target", p1_target, 32'h14);

    // no bypass: same-cycle lookup sees the old target
    if_pc = 32'h50;
    upd_pc = 32'h50; upd_is_jump = 1'b1; upd_taken = 1'b1;
    upd_target = 32'h60; upd_valid = 1'b1;
    #1;
    chk("nobyp_old", p1_target, 32'h40);
    @(posedge clock); #1;
    upd_valid = 1'b0;
    chk("nobyp_new", p1_target, 32'h60);

    // flush wins over a same-cycle allocate; stats still count
    flush_all = 1'b1;
    upd(32'h30, 1'b0, 1'b1, 32'h80, 1'b1);
    flush_all = 1'b0;
    look(32'h30);
    chk("fl_30_taken",  {31'b0, p1_taken}, 32'h0);
    chk("fl_30_target", p1_target, 32'h34);
    look(32'h50);
    chk("fl_50_taken",  {31'b0, p1_taken}, 32'h0);
    chk("fl_50_target", p1_target, 32'h54);
    chk("fl_res", s1_res, 32'd13);
    chk("fl_mis", s1_mis, 32'd2);

    // PC wrap on the fall-through target
    look(32'hFFFF_FFFC);
    chk("wrap_target", p1_target, 32'h0);

    // mid-training reset; updates during reset are ignored
    upd(32'h30, 1'b0, 1'b1, 32'h80, 1'b1);
    look(32'h30);
    chk("pre_rst_taken", {31'b0, p1_taken}, 32'h1);
    reset = 1'b0;
    upd(32'h30, 1'b0, 1'b1, 32'h90, 1'b1);
    look(32'h30);
    chk("mid_rst_taken", {31'b0, p1_taken}, 32'h0);
    chk("mid_rst_res",   s1_res, 32'h0);
    chk("mid_rst_mis",   s0_mis, 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_res", s1_res, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
